mem_arbiter: RTL

//  Sits between the instruction cache (IC) and the store/load buffer (LSB) and
//  the single-port byte-serial memory controller. Grants the controller to one

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbiter granting the byte-serial memory controller to either the IC or the LSB.
// Optional IC starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_ack,
  output logic [31:0] ic_data,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [2:0]  lsb_size,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_ack,
  output logic [31:0] lsb_rdata,
  output logic        mc_ic_valid,
  output logic [31:0] mc_ic_addr,
  input  logic        mc_ic_done,
  input  logic [31:0] mc_ic_inst,
  output logic        mc_slb_valid,
  output logic        mc_slb_wr,
  output logic [31:0] mc_slb_addr,
  output logic [2:0]  mc_slb_siz,
  output logic [31:0] mc_slb_din,
  input  logic [31:0] mc_slb_dout,
  input  logic        mc_slb_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, G_IC, G_LSB, DRAIN} state_t;

  state_t      state, state_next;
  logic        ic_ack_next, lsb_ack_next;
  logic [31:0] ic_data_next, lsb_rdata_next;
  logic        mc_ic_valid_next, mc_slb_valid_next, mc_slb_wr_next;
  logic [31:0] mc_ic_addr_next, mc_slb_addr_next, mc_slb_din_next;
  logic [2:0]  mc_slb_siz_next;

  logic ic_ok, lsb_ok, starved, take_ic, take_lsb;

  // Flush kills speculative requests: fetches and loads, never stores.
  assign ic_ok    = ic_req & ~flush;
  assign lsb_ok   = lsb_req & ~(flush & ~lsb_wr);
  assign take_ic  = (state == IDLE) & ic_ok & (starved | ~lsb_ok);
  assign take_lsb = (state == IDLE) & lsb_ok & ~take_ic;
  assign busy     = (state != IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_cnt, starve_cnt_next;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (rdy) begin
      if (!ic_req || take_ic || state == G_IC)
        starve_cnt_next = '0;
      else if (!starved)
        starve_cnt_next = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_cnt <= '0;
    else      starve_cnt <= starve_cnt_next;
  end
`else
  logic [CNT_W-1:0] unused_limit;
  assign unused_limit = CNT_W'(STARVE_LIMIT);
  assign starved      = 1'b0;
`endif

  always_comb begin
    state_next        = state;
    ic_ack_next       = ic_ack;
    lsb_ack_next      = lsb_ack;
    ic_data_next      = ic_data;
    lsb_rdata_next    = lsb_rdata;
    mc_ic_valid_next  = mc_ic_valid;
    mc_ic_addr_next   = mc_ic_addr;
    mc_slb_valid_next = mc_slb_valid;
    mc_slb_wr_next    = mc_slb_wr;
    mc_slb_addr_next  = mc_slb_addr;
    mc_slb_siz_next   = mc_slb_siz;
    mc_slb_din_next   = mc_slb_din;
    if (rdy) begin
      ic_ack_next  = 1'b0;
      lsb_ack_next = 1'b0;
      case (state)
        IDLE: begin
          if (take_ic) begin
            state_next       = G_IC;
            mc_ic_valid_next = 1'b1;
            mc_ic_addr_next  = ic_addr;
          end else if (take_lsb) begin
            state_next        = G_LSB;
            mc_slb_valid_next = 1'b1;
            mc_slb_wr_next    = lsb_wr;
            mc_slb_addr_next  = lsb_addr;
            mc_slb_siz_next   = (lsb_size == 3'd1 || lsb_size == 3'd2) ? lsb_size : 3'd4;
            mc_slb_din_next   = lsb_wdata;
          end
        end
        G_IC: begin
          // A done coinciding with flush still delivers the instruction.
          if (mc_ic_done) begin
            ic_data_next     = mc_ic_inst;
            ic_ack_next      = 1'b1;
            mc_ic_valid_next = 1'b0;
            state_next       = DRAIN;
          end else if (flush) begin
            mc_ic_valid_next = 1'b0;
            state_next       = DRAIN;
          end
        end
        G_LSB: begin
          if (mc_slb_done) begin
            lsb_rdata_next    = mc_slb_dout;
            lsb_ack_next      = 1'b1;
            mc_slb_valid_next = 1'b0;
            state_next        = DRAIN;
          end else if (flush && !mc_slb_wr) begin
            mc_slb_valid_next = 1'b0;
            state_next        = DRAIN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ic_ack       <= 1'b0;
      lsb_ack      <= 1'b0;
      ic_data      <= '0;
      lsb_rdata    <= '0;
      mc_ic_valid  <= 1'b0;
      mc_ic_addr   <= '0;
      mc_slb_valid <= 1'b0;
      mc_slb_wr    <= 1'b0;
      mc_slb_addr  <= '0;
      mc_slb_siz   <= '0;
      mc_slb_din   <= '0;
    end else begin
      state        <= state_next;
      ic_ack       <= ic_ack_next;
      lsb_ack      <= lsb_ack_next;
      ic_data      <= ic_data_next;
      lsb_rdata    <= lsb_rdata_next;
      mc_ic_valid  <= mc_ic_valid_next;
      mc_ic_addr   <= mc_ic_addr_next;
      mc_slb_valid <= mc_slb_valid_next;
      mc_slb_wr    <= mc_slb_wr_next;
      mc_slb_addr  <= mc_slb_addr_next;
      mc_slb_siz   <= mc_slb_siz_next;
      mc_slb_din   <= mc_slb_din_next;
    end
  end

endmodule
